// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined floating-point adder/subtractor, one op per cycle.
// Inputs are registered (stage 0). Five stages follow: compare, align,
// add/sub, normalise, and round/output. A result appears 5 edges after the
// input is sampled.
// Optional macro FP_ROUND_RNE_EN: round-to-nearest-even using G/R/S.
// Without it the result is truncated (round toward zero).
// Subnormals are flushed to zero. An all-ones exponent is infinity. NaN is not supported.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 zero,
  output logic                 ovf
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SW     = MAN_W + 4;          // hidden + man + G,R,S
  localparam int XW     = EXP_W + 2;          // exponent with carry headroom
  localparam int STAGES = 5;
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [XW-1:0]    EXP_MAX_X = {2'b00, EXP_MAX};

  logic [STAGES:0] vld_pipe;

  // valid bits travel alongside the data; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end
  assign out_valid = vld_pipe[STAGES];

  // ---------------- stage 0: input capture
  logic         s0_op;
  logic [W-1:0] s0_a, s0_b;

  // register the raw operands
  always_ff @(posedge clk) begin
    s0_op <= op;
    s0_a  <= a;
    s0_b  <= b;
  end

  // ---------------- stage 1: classify, compare, pick big/small, specials
  logic             a_sgn, b_sgn, a_inf, b_inf, a_zro, b_zro, a_big;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic             c1_spc, c1_spc_zero;
  logic [W-1:0]     c1_spc_out;

  // operand classes and infinity/zero-zero short-circuit results
  always_comb begin
    a_sgn = s0_a[W-1];
    b_sgn = s0_b[W-1] ^ s0_op;
    a_exp = s0_a[W-2:MAN_W];
    b_exp = s0_b[W-2:MAN_W];
    a_inf = (a_exp == EXP_MAX);
    b_inf = (b_exp == EXP_MAX);
    a_zro = (a_exp == '0);
    b_zro = (b_exp == '0);
    a_big = (s0_a[W-2:0] >= s0_b[W-2:0]);
    c1_spc      = 1'b0;
    c1_spc_zero = 1'b0;
    c1_spc_out  = '0;
    if (a_inf || b_inf) begin
      c1_spc = 1'b1;
      if (a_inf && b_inf && (a_sgn != b_sgn))
        c1_spc_out = {1'b0, EXP_MAX, {MAN_W{1'b0}}};
      else
        c1_spc_out = {(a_big ? a_sgn : b_sgn), EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zro && b_zro) begin
      c1_spc      = 1'b1;
      c1_spc_zero = 1'b1;
      c1_spc_out  = {a_sgn & b_sgn, {(W-1){1'b0}}};
    end
  end

  logic             s1_sgn, s1_sub, s1_sml_zro, s1_spc, s1_spc_zero;
  logic [EXP_W-1:0] s1_big_exp, s1_sml_exp;
  logic [MAN_W-1:0] s1_big_man, s1_sml_man;
  logic [W-1:0]     s1_spc_out;

  // order the operands by magnitude (A wins ties)
  always_ff @(posedge clk) begin
    s1_sgn      <= a_big ? a_sgn : b_sgn;
    s1_sub      <= a_sgn ^ b_sgn;
    s1_big_exp  <= a_big ? a_exp : b_exp;
    s1_big_man  <= a_big ? s0_a[MAN_W-1:0] : s0_b[MAN_W-1:0];
    s1_sml_exp  <= a_big ? b_exp : a_exp;
    s1_sml_man  <= a_big ? s0_b[MAN_W-1:0] : s0_a[MAN_W-1:0];
    s1_sml_zro  <= a_big ? b_zro : a_zro;
    s1_spc      <= c1_spc;
    s1_spc_zero <= c1_spc_zero;
    s1_spc_out  <= c1_spc_out;
  end

  // ---------------- stage 2: align small significand
  logic [EXP_W-1:0] exp_diff;
  logic [31:0]      sh;
  logic [SW-1:0]    sml_sig, sml_aln;
  logic [2*SW-1:0]  sml_ext;

  // right shift with everything below S folded into sticky
  always_comb begin
    exp_diff = s1_big_exp - s1_sml_exp;
    sh       = 32'(exp_diff);
    if (sh > 32'(SW)) sh = 32'(SW);
    sml_sig  = s1_sml_zro ? '0 : {1'b1, s1_sml_man, 3'b000};
    sml_ext  = {sml_sig, {SW{1'b0}}} >> sh;
    sml_aln  = {sml_ext[2*SW-1:SW+1], sml_ext[SW] | (|sml_ext[SW-1:0])};
  end

  logic             s2_sgn, s2_sub, s2_spc, s2_spc_zero;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_big_sig, s2_sml_sig;
  logic [W-1:0]     s2_spc_out;

  // aligned significands
  always_ff @(posedge clk) begin
    s2_sgn      <= s1_sgn;
    s2_sub      <= s1_sub;
    s2_exp      <= s1_big_exp;
    s2_big_sig  <= {1'b1, s1_big_man, 3'b000};
    s2_sml_sig  <= sml_aln;
    s2_spc      <= s1_spc;
    s2_spc_zero <= s1_spc_zero;
    s2_spc_out  <= s1_spc_out;
  end

  // ---------------- stage 3: add / subtract
  logic             s3_sgn, s3_spc, s3_spc_zero;
  logic [EXP_W-1:0] s3_exp;
  logic [SW:0]      s3_sum;
  logic [W-1:0]     s3_spc_out;

  // big >= small, so the difference never goes negative
  always_ff @(posedge clk) begin
    s3_sum      <= s2_sub ? ({1'b0, s2_big_sig} - {1'b0, s2_sml_sig})
                          : ({1'b0, s2_big_sig} + {1'b0, s2_sml_sig});
    s3_sgn      <= s2_sgn;
    s3_exp      <= s2_exp;
    s3_spc      <= s2_spc;
    s3_spc_zero <= s2_spc_zero;
    s3_spc_out  <= s2_spc_out;
  end

  // ---------------- stage 4: normalise
  logic [31:0]   lzc;
  logic [SW-1:0] n_sig;
  logic [XW-1:0] n_exp;
  logic          n_zero;

  // carry -> shift right; otherwise leading-zero shift left, flush on underflow
  always_comb begin
    lzc = '0;
    for (int i = 0; i < SW; i++)
      if (s3_sum[i]) lzc = 32'(SW - 1 - i);
    n_sig  = s3_sum[SW-1:0];
    n_exp  = {2'b00, s3_exp};
    n_zero = 1'b0;
    if (s3_sum[SW]) begin
      n_sig = {s3_sum[SW:2], s3_sum[1] | s3_sum[0]};
      n_exp = n_exp + XW'(1);
    end else if (s3_sum == '0) begin
      n_zero = 1'b1;
    end else begin
      n_sig = s3_sum[SW-1:0] << lzc;
      if (32'(s3_exp) <= lzc) n_zero = 1'b1;
      else                    n_exp  = n_exp - XW'(lzc);
    end
  end

  logic          s4_sgn, s4_zero, s4_spc, s4_spc_zero;
  logic [SW-1:0] s4_sig;
  logic [XW-1:0] s4_exp;
  logic [W-1:0]  s4_spc_out;

  // normalised significand and exponent
  always_ff @(posedge clk) begin
    s4_sig      <= n_sig;
    s4_exp      <= n_exp;
    s4_sgn      <= s3_sgn;
    s4_zero     <= n_zero;
    s4_spc      <= s3_spc;
    s4_spc_zero <= s3_spc_zero;
    s4_spc_out  <= s3_spc_out;
  end

  // ---------------- stage 5: round and output
  logic             up;
  logic [MAN_W+1:0] rnd;
  logic [XW-1:0]    r_exp;
  logic [MAN_W-1:0] r_man;

  // rounding increment and re-normalise on mantissa carry-out
  always_comb begin
`ifdef FP_ROUND_RNE_EN
    up = s4_sig[2] & (s4_sig[3] | s4_sig[1] | s4_sig[0]);
`else
    up = &{1'b0, s4_sig[2:0]};  // GRS discarded: always zero
`endif
    rnd   = {1'b0, s4_sig[SW-1:3]} + (MAN_W+2)'(up);
    r_exp = s4_exp;
    r_man = rnd[MAN_W-1:0];
    if (rnd[MAN_W+1]) begin
      r_exp = s4_exp + XW'(1);
      r_man = rnd[MAN_W:1];
    end
  end

  // outputs change only when a valid result emerges
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (vld_pipe[STAGES-1]) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
      if (s4_spc) begin
        out  <= s4_spc_out;
        zero <= s4_spc_zero;
      end else if (s4_zero) begin
        out  <= '0;
        zero <= 1'b1;
      end else if (r_exp >= EXP_MAX_X) begin
        out <= {s4_sgn, EXP_MAX, {MAN_W{1'b0}}};
        ovf <= 1'b1;
      end else begin
        out <= {s4_sgn, r_exp[EXP_W-1:0], r_man};
      end
    end
  end
endmodule
